// File: rtl/panel_timing_pkg.sv
// Shared types and helpers for the HUB75 scan/PWM timing generator.
// Holds the phase state encoding, the modulation mode constants and the display-length rule.
package panel_timing_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_BLANK   = 3'd2,
        ST_LATCH   = 3'd3,
        ST_DISPLAY = 3'd4
    } state_e;

    localparam logic MODE_LINEAR = 1'b0;
    localparam logic MODE_BCM    = 1'b1;

    // BCM weights each bit-plane by 2^sub; linear subframes all share the base time.
    function automatic logic [31:0] display_len(input logic mode,
                                                input logic [31:0] sub,
                                                input logic [31:0] base);
        if (mode == MODE_BCM) begin
            return base << sub;
        end else begin
            return base;
        end
    endfunction

endpackage

// File: rtl/panel_phase_timer.sv
// Loadable down-counter with a done flag; one instance times every fixed-length scan phase.
// done is high while the count sits at zero, i.e. in the last cycle of a phase.
module panel_phase_timer #(
    parameter int W = 8
) (
    input  logic         clk_in,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins, otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/panel_scan_timing.sv
// HUB75 scan and PWM/BCM timing generator: SHIFT -> BLANK -> LATCH -> DISPLAY per scanline.
// All panel-facing outputs are registered and change together with the phase state.
import panel_timing_pkg::*;

module panel_scan_timing #(
    parameter int COL_BITS     = 6,
    parameter int LINE_BITS    = 3,
    parameter int PWM_WIDTH    = 12,
    parameter int BCM_MODE     = 0,
    parameter int BLANK_CYCLES = 2,
    parameter int DISPLAY_BASE = 4
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 enable,
    output logic [LINE_BITS-1:0] line,
    output logic [COL_BITS-1:0]  col,
    output logic [PWM_WIDTH-1:0] sub,
    output logic                 shift_en,
    output logic                 lat,
    output logic                 oe_n,
    output logic [LINE_BITS-1:0] addr,
    output logic                 frame_clk,
    output logic                 busy
);

    localparam int DISP_W = PWM_WIDTH + $clog2(DISPLAY_BASE + 1);
    localparam int TW0    = (DISP_W > COL_BITS + 1) ? DISP_W : COL_BITS + 1;
    localparam int TW     = (TW0 > $clog2(BLANK_CYCLES + 1)) ? TW0 : $clog2(BLANK_CYCLES + 1);
    localparam logic            MODE       = (BCM_MODE != 0) ? MODE_BCM : MODE_LINEAR;
    localparam logic [TW-1:0]   SHIFT_LOAD = TW'((1 << COL_BITS) - 1);
    localparam logic [TW-1:0]   BLANK_LOAD = TW'(BLANK_CYCLES - 1);
    localparam logic [LINE_BITS-1:0] LINE_MAX = {LINE_BITS{1'b1}};
    localparam logic [PWM_WIDTH-1:0] SUB_LAST =
        (BCM_MODE != 0) ? PWM_WIDTH'(PWM_WIDTH - 1) : {PWM_WIDTH{1'b1}};

    state_e                 state_q, state_d;
    logic [COL_BITS-1:0]    col_q, col_d;
    logic [LINE_BITS-1:0]   line_q, line_d;
    logic [PWM_WIDTH-1:0]   sub_q, sub_d;
    logic [LINE_BITS-1:0]   addr_q, addr_d;
    logic                   shift_en_q, shift_en_d;
    logic                   lat_q, lat_d;
    logic                   oe_n_q, oe_n_d;
    logic                   frame_clk_q, frame_clk_d;
    logic                   busy_q, busy_d;
    logic                   stop_q, stop_d;
    logic                   tmr_load_s;
    logic [TW-1:0]          tmr_val_s;
    logic                   tmr_done_s;
    logic [TW-1:0]          disp_load_s;

    assign disp_load_s = TW'(display_len(MODE, 32'(sub_q), 32'(DISPLAY_BASE)) - 32'd1);

    panel_phase_timer #(.W(TW)) u_timer (
        .clk_in   (clk_in),
        .reset    (reset),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .done     (tmr_done_s)
    );

    // Phase sequencing and next values of every registered output.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        line_d      = line_q;
        sub_d       = sub_q;
        addr_d      = addr_q;
        stop_d      = stop_q;
        shift_en_d  = 1'b0;
        lat_d       = 1'b0;
        oe_n_d      = 1'b1;
        frame_clk_d = 1'b0;
        busy_d      = 1'b1;
        tmr_load_s  = 1'b0;
        tmr_val_s   = '0;

        // A stop request is sticky until the current line has been displayed.
        if (state_q != ST_IDLE && !enable) begin
            stop_d = 1'b1;
        end else begin
            stop_d = stop_q;
        end

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                stop_d = 1'b0;
                if (enable) begin
                    state_d     = ST_SHIFT;
                    col_d       = '0;
                    line_d      = '0;
                    sub_d       = '0;
                    shift_en_d  = 1'b1;
                    frame_clk_d = 1'b1;
                    busy_d      = 1'b1;
                    tmr_load_s  = 1'b1;
                    tmr_val_s   = SHIFT_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (tmr_done_s) begin
                    state_d    = ST_BLANK;
                    col_d      = '0;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = BLANK_LOAD;
                end else begin
                    col_d      = col_q + COL_BITS'(1);
                    shift_en_d = 1'b1;
                    oe_n_d     = oe_n_q;
                end
            end
            ST_BLANK: begin
                if (tmr_done_s) begin
                    state_d = ST_LATCH;
                    lat_d   = 1'b1;
                end else begin
                    state_d = ST_BLANK;
                end
            end
            ST_LATCH: begin
                state_d    = ST_DISPLAY;
                addr_d     = line_q;
                oe_n_d     = 1'b0;
                tmr_load_s = 1'b1;
                tmr_val_s  = disp_load_s;
            end
            ST_DISPLAY: begin
                if (!tmr_done_s) begin
                    oe_n_d = 1'b0;
                end else if (stop_q || !enable) begin
                    state_d = ST_IDLE;
                    col_d   = '0;
                    line_d  = '0;
                    sub_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    // Keep the just-displayed line lit while the next one shifts in.
                    state_d    = ST_SHIFT;
                    col_d      = '0;
                    shift_en_d = 1'b1;
                    oe_n_d     = 1'b0;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = SHIFT_LOAD;
                    if (line_q == LINE_MAX) begin
                        line_d = '0;
                        if (sub_q == SUB_LAST) begin
                            sub_d       = '0;
                            frame_clk_d = 1'b1;
                        end else begin
                            sub_d = sub_q + PWM_WIDTH'(1);
                        end
                    end else begin
                        line_d = line_q + LINE_BITS'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            line_q      <= '0;
            sub_q       <= '0;
            addr_q      <= '0;
            shift_en_q  <= 1'b0;
            lat_q       <= 1'b0;
            oe_n_q      <= 1'b1;
            frame_clk_q <= 1'b0;
            busy_q      <= 1'b0;
            stop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            line_q      <= line_d;
            sub_q       <= sub_d;
            addr_q      <= addr_d;
            shift_en_q  <= shift_en_d;
            lat_q       <= lat_d;
            oe_n_q      <= oe_n_d;
            frame_clk_q <= frame_clk_d;
            busy_q      <= busy_d;
            stop_q      <= stop_d;
        end
    end

    assign line      = line_q;
    assign col       = col_q;
    assign sub       = sub_q;
    assign shift_en  = shift_en_q;
    assign lat       = lat_q;
    assign oe_n      = oe_n_q;
    assign addr      = addr_q;
    assign frame_clk = frame_clk_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_panel_scan_timing.sv
// Bench for panel_scan_timing: small linear and BCM instances checked cycle by cycle against
// a line-level timing model, plus a default-parameter instance checked for its line period.
module tb_panel_scan_timing;

    logic clk_in = 1'b0;
    logic reset  = 1'b1;
    logic en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   sel   = 0;
    int   addr0 = 0;

    always #5 clk_in = ~clk_in;

    logic [0:0] a_line, a_addr, b_line, b_addr;
    logic [1:0] a_col, a_sub, b_col, b_sub;
    logic a_sh, a_lat, a_oe, a_fc, a_busy, b_sh, b_lat, b_oe, b_fc, b_busy;
    logic [2:0] c_line, c_addr;
    logic [5:0] c_col;
    logic [11:0] c_sub;
    logic c_sh, c_lat, c_oe, c_fc, c_busy;

    panel_scan_timing #(.COL_BITS(2), .LINE_BITS(1), .PWM_WIDTH(2), .BCM_MODE(0),
                        .BLANK_CYCLES(1), .DISPLAY_BASE(3)) dut_a (
        .clk_in(clk_in), .reset(reset), .enable(en_a), .line(a_line), .col(a_col),
        .sub(a_sub), .shift_en(a_sh), .lat(a_lat), .oe_n(a_oe), .addr(a_addr),
        .frame_clk(a_fc), .busy(a_busy));

    panel_scan_timing #(.COL_BITS(2), .LINE_BITS(1), .PWM_WIDTH(2), .BCM_MODE(1),
                        .BLANK_CYCLES(1), .DISPLAY_BASE(3)) dut_b (
        .clk_in(clk_in), .reset(reset), .enable(en_b), .line(b_line), .col(b_col),
        .sub(b_sub), .shift_en(b_sh), .lat(b_lat), .oe_n(b_oe), .addr(b_addr),
        .frame_clk(b_fc), .busy(b_busy));

    panel_scan_timing dut_c (
        .clk_in(clk_in), .reset(reset), .enable(en_c), .line(c_line), .col(c_col),
        .sub(c_sub), .shift_en(c_sh), .lat(c_lat), .oe_n(c_oe), .addr(c_addr),
        .frame_clk(c_fc), .busy(c_busy));

    logic [31:0] o_line, o_col, o_sub, o_addr;
    logic o_sh, o_lat, o_oe, o_fc, o_busy;

    always_comb begin
        if (sel == 1) begin
            o_line = 32'(b_line); o_col = 32'(b_col); o_sub = 32'(b_sub); o_addr = 32'(b_addr);
            o_sh = b_sh; o_lat = b_lat; o_oe = b_oe; o_fc = b_fc; o_busy = b_busy;
        end else begin
            o_line = 32'(a_line); o_col = 32'(a_col); o_sub = 32'(a_sub); o_addr = 32'(a_addr);
            o_sh = a_sh; o_lat = a_lat; o_oe = a_oe; o_fc = a_fc; o_busy = a_busy;
        end
    end

    typedef struct packed {
        logic [31:0] line, col, sub, addr;
        logic shift_en, lat, oe_n, frame_clk, last;
    } exp_t;

    // Expected outputs k cycles after a start, built from whole-line periods:
    // 4 shift + 1 blank + 1 latch + T display, T = 3 (linear) or 3<<sub (BCM).
    function automatic exp_t model(input int mode, input int k, input int a0);
        int t, s, l, prev, per;
        bit first;
        exp_t e;
        t = k; s = 0; l = 0; prev = a0; first = 1'b1;
        per = 6 + (mode != 0 ? (3 << s) : 3);
        while (t >= per) begin
            t = t - per; prev = l; first = 1'b0;
            if (l == 1) begin
                l = 0;
                s = (mode != 0) ? ((s == 1) ? 0 : s + 1) : ((s + 1) % 4);
            end else begin
                l = l + 1;
            end
            per = 6 + (mode != 0 ? (3 << s) : 3);
        end
        e = '0;
        e.line = l; e.sub = s; e.addr = prev; e.oe_n = 1'b1;
        if (t < 4) begin
            e.col = t; e.shift_en = 1'b1; e.oe_n = first ? 1'b1 : 1'b0;
            e.frame_clk = (t == 0 && l == 0 && s == 0);
        end else if (t == 5) begin
            e.lat = 1'b1;
        end else if (t >= 6) begin
            e.oe_n = 1'b0; e.addr = l; e.last = (t == per - 1);
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_oe_n"}, 32'(o_oe), 32'd1);
        chk({tag, "_shift_en"}, 32'(o_sh), 32'd0);
        chk({tag, "_lat"}, 32'(o_lat), 32'd0);
        chk({tag, "_frame_clk"}, 32'(o_fc), 32'd0);
        chk({tag, "_line"}, o_line, 32'd0);
        chk({tag, "_col"}, o_col, 32'd0);
        chk({tag, "_sub"}, o_sub, 32'd0);
    endtask

    task automatic chk_model(input exp_t m);
        chk("line", o_line, m.line);
        chk("col", o_col, m.col);
        chk("sub", o_sub, m.sub);
        chk("addr", o_addr, m.addr);
        chk("shift_en", 32'(o_sh), 32'(m.shift_en));
        chk("lat", 32'(o_lat), 32'(m.lat));
        chk("oe_n", 32'(o_oe), 32'(m.oe_n));
        chk("frame_clk", 32'(o_fc), 32'(m.frame_clk));
        chk("busy", 32'(o_busy), 32'd1);
    endtask

    task automatic set_en(input logic v);
        if (sel == 1) en_b = v; else en_a = v;
    endtask

    function automatic logic cur_en();
        return (sel == 1) ? en_b : en_a;
    endfunction

    // One run from a start: enable drops at cycle d, may come back before the stop completes.
    task automatic run(input int mode, input int d, input bit restart);
        int k;
        bit stopping, fin;
        exp_t m;
        k = 0; stopping = 1'b0; fin = 1'b0; m = '0;
        while (!fin && k < 1000) begin
            @(negedge clk_in);
            m = model(mode, k, addr0);
            chk_model(m);
            if (k == d) begin
                set_en(1'b0); stopping = 1'b1;
            end else if (stopping && !cur_en() && $urandom_range(0, 3) == 0) begin
                set_en(1'b1);
            end
            if (stopping && m.last) fin = 1'b1;
            k++;
        end
        chk("run_completes", 32'(fin), 32'd1);
        addr0 = int'(m.line);
        @(negedge clk_in);
        chk_idle("stop_idle");
        if (!restart) begin
            set_en(1'b0);
        end else if (!cur_en()) begin
            @(negedge clk_in);
            chk_idle("stop_hold");
            set_en(1'b1);
        end
    endtask

    initial begin
        int n, sc, oc;
        bit seen;
        // Reset values while held in reset.
        repeat (2) @(negedge clk_in);
        chk_idle("reset");
        chk("reset_addr", o_addr, 32'd0);
        reset = 1'b0;

        // Start, then hit reset in the middle of DISPLAY.
        en_a = 1'b1;
        for (int k = 0; k < 7; k++) @(negedge clk_in);
        chk("pre_reset_oe_n", 32'(o_oe), 32'd0);
        reset = 1'b1;
        #1;
        chk_idle("async_reset");
        @(negedge clk_in);
        en_a = 1'b0;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            chk_idle("idle_hold");
            chk("idle_addr", o_addr, 32'd0);
        end

        // Linear mode: directed stop in line 1 shift, then random stop points.
        addr0 = 0;
        sel = 0;
        set_en(1'b1);
        run(0, 10, 1'b1);
        for (int i = 0; i < 5; i++) run(0, int'($urandom_range(0, 200)), i < 4);

        // BCM mode.
        addr0 = 0;
        sel = 1;
        @(negedge clk_in);
        set_en(1'b1);
        run(1, 50, 1'b1);
        for (int i = 0; i < 5; i++) run(1, int'($urandom_range(0, 120)), i < 4);

        // Default parameters: 71-cycle line, 64 shift cycles, previous line lit through shift.
        @(negedge clk_in);
        en_c = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk_in);
            if (c_lat) seen = 1'b1;
        end
        chk("c_first_lat", 32'(seen), 32'd1);
        n = 0; sc = 0; oc = 0; seen = 1'b0;
        while (!seen && n < 300) begin
            @(negedge clk_in);
            n++;
            if (c_sh) sc++;
            if (!c_oe) oc++;
            if (c_lat) seen = 1'b1;
        end
        chk("c_line_period", 32'(n), 32'd71);
        chk("c_shift_cycles", 32'(sc), 32'd64);
        chk("c_lit_cycles", 32'(oc), 32'd68);
        chk("c_line_at_lat", 32'(c_line), 32'd1);
        @(negedge clk_in);
        chk("c_addr_after_lat", 32'(c_addr), 32'd1);
        en_c = 1'b0;
        n = 0;
        while (c_busy && n < 300) begin
            @(negedge clk_in);
            n++;
        end
        chk("c_stops", 32'(c_busy), 32'd0);
        chk("c_stop_oe_n", 32'(c_oe), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
